// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the inst/data requesters, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory view.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output inst_req, inst_addr, inst_cancel,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like port between fetch and data requesters: data-priority arbitration with
// inst anti-starvation, grant lock until accept, and an owner FIFO routing in-order responses.
module mem_port_arbiter #(
    parameter int unsigned OUTSTANDING  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

    localparam int unsigned      PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [2:0]       DEPTH    = 3'(OUTSTANDING);
    localparam logic [3:0]       LIMIT    = 4'(STARVE_LIMIT);

    owner_e                 fifo_own_q [OUTSTANDING];
    owner_e                 fifo_own_d [OUTSTANDING];
    logic [OUTSTANDING-1:0] fifo_disc_q, fifo_disc_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]             count_q, count_d;
    logic                   lock_valid_q, lock_valid_d;
    owner_e                 lock_owner_q, lock_owner_d;
    logic [3:0]             starve_cnt_q, starve_cnt_d;

    owner_e owner;
    owner_e head_own;
    logic   sel_req;
    logic   fifo_full;
    logic   accept;
    logic   pop;
    logic   head_disc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        if (lock_valid_q) begin
            owner = lock_owner_q;
        end else if (bus.data_req && !(bus.inst_req && (starve_cnt_q == LIMIT))) begin
            owner = OWN_DATA;
        end else begin
            owner = OWN_INST;
        end
    end

    // Full is judged on the registered count only, so a same-cycle pop never re-opens mem_req.
    assign fifo_full   = (count_q == DEPTH);
    assign sel_req     = (owner == OWN_DATA) ? bus.data_req : bus.inst_req;
    assign bus.mem_req = resetn && sel_req && !fifo_full;
    assign accept      = bus.mem_req && bus.mem_addr_ok;

    always_comb begin
        bus.mem_wr    = 1'b0;
        bus.mem_wstrb = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.mem_req) begin
            if (owner == OWN_DATA) begin
                bus.mem_wr    = bus.data_wr;
                bus.mem_wstrb = bus.data_wstrb;
                bus.mem_addr  = bus.data_addr;
                bus.mem_wdata = bus.data_wdata;
            end else begin
                bus.mem_addr  = bus.inst_addr;
            end
        end
    end

    assign bus.inst_addr_ok = accept && (owner == OWN_INST);
    assign bus.data_addr_ok = accept && (owner == OWN_DATA);

    // A cancel in this cycle already kills an inst response arriving in the same cycle.
    assign pop       = bus.mem_data_ok && (count_q != '0);
    assign head_own  = fifo_own_q[rd_ptr_q];
    assign head_disc = fifo_disc_q[rd_ptr_q] || bus.inst_cancel;

    assign bus.data_data_ok = pop && (head_own == OWN_DATA);
    assign bus.inst_data_ok = pop && (head_own == OWN_INST) && !head_disc;
    assign bus.data_rdata   = bus.data_data_ok ? bus.mem_rdata : '0;
    assign bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : '0;

    always_comb begin
        fifo_own_d   = fifo_own_q;
        fifo_disc_d  = fifo_disc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + {2'b00, accept} - {2'b00, pop};
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        starve_cnt_d = starve_cnt_q;

        if (bus.inst_cancel) begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                if (fifo_own_q[i] == OWN_INST) begin
                    fifo_disc_d[i] = 1'b1;
                end
            end
        end
        // The push follows the cancel sweep so a fetch accepted in the cancel cycle stays live.
        if (accept) begin
            fifo_own_d[wr_ptr_q]  = owner;
            fifo_disc_d[wr_ptr_q] = 1'b0;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (accept) begin
            lock_valid_d = 1'b0;
        end else if (bus.mem_req) begin
            lock_valid_d = 1'b1;
            lock_owner_d = owner;
        end

        if (!bus.inst_req || (accept && (owner == OWN_INST))) begin
            starve_cnt_d = '0;
        end else if ((owner == OWN_DATA) && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                fifo_own_q[i] <= OWN_INST;
            end
            fifo_disc_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWN_INST;
            starve_cnt_q <= '0;
        end else begin
            fifo_own_q   <= fifo_own_d;
            fifo_disc_q  <= fifo_disc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: priority/starvation, lock, FIFO full, cancel and reset.
module tb_mem_port_arbiter;
    logic clk;
    logic resetn;
    int   n_assert;
    int   n_fail;

    localparam logic [31:0] IA = 32'h1c000000;
    localparam logic [31:0] DA = 32'h80001000;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .OUTSTANDING  (2),
        .STARVE_LIMIT (4)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.inst_cancel = 1'b0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_wstrb  = '0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic dreq(input logic wr, input logic [3:0] strb, input logic [31:0] a, input logic [31:0] d);
        bus.data_req   = 1'b1;
        bus.data_wr    = wr;
        bus.data_wstrb = strb;
        bus.data_addr  = a;
        bus.data_wdata = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        idle();
        bus.inst_req  = 1'b1;
        bus.inst_addr = IA;
        #2;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_inst_addr_ok", bus.inst_addr_ok, 0);
        bus.inst_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        cyc();

        // Priority: data wins 4 cycles, inst on the 5th, one-cycle responses routed in order.
        for (int k = 0; k <= 6; k++) begin
            idle();
            bus.inst_req  = (k <= 4);
            bus.inst_addr = IA;
            if (k <= 5) dreq(1'b0, 4'h0, DA + 32'(4 * ((k < 4) ? k : 4)), 32'h5555aaaa);
            bus.mem_addr_ok = 1'b1;
            bus.mem_data_ok = (k >= 1);
            bus.mem_rdata   = 32'ha0000000 + 32'(k);
            #1;
            chk("pri_data_addr_ok", bus.data_addr_ok, (k < 4) || (k == 5));
            chk("pri_inst_addr_ok", bus.inst_addr_ok, k == 4);
            chk("pri_mem_req", bus.mem_req, k <= 5);
            if (k == 4) begin
                chk("pri_inst_mem_addr", bus.mem_addr, IA);
                chk("pri_inst_mem_wdata", bus.mem_wdata, 0);
            end else if (k <= 5) begin
                chk("pri_data_mem_addr", bus.mem_addr, DA + 32'(4 * ((k < 4) ? k : 4)));
            end
            if (k >= 1) begin
                chk("pri_data_data_ok", bus.data_data_ok, k != 5);
                chk("pri_inst_data_ok", bus.inst_data_ok, k == 5);
                if (k == 5) chk("pri_inst_rdata", bus.inst_rdata, 32'ha0000005);
                else        chk("pri_data_rdata", bus.data_rdata, 32'ha0000000 + 32'(k));
            end
            cyc();
        end

        // Lock: data write held for three refused cycles while inst rises.
        for (int c = 0; c < 4; c++) begin
            idle();
            dreq(1'b1, 4'hf, 32'h1c000010, 32'hdeadbeef);
            bus.inst_req    = (c >= 1);
            bus.inst_addr   = 32'h1c004000;
            bus.mem_addr_ok = (c == 3);
            #1;
            chk("lock_mem_req", bus.mem_req, 1);
            chk("lock_mem_addr", bus.mem_addr, 32'h1c000010);
            chk("lock_mem_wdata", bus.mem_wdata, 32'hdeadbeef);
            chk("lock_mem_wstrb", bus.mem_wstrb, 4'hf);
            chk("lock_mem_wr", bus.mem_wr, 1);
            chk("lock_data_addr_ok", bus.data_addr_ok, c == 3);
            chk("lock_inst_addr_ok", bus.inst_addr_ok, 0);
            cyc();
        end
        idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c004000;
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0;
        #1;
        chk("lock_inst_grant", bus.inst_addr_ok, 1);
        chk("lock_wr_ack", bus.data_data_ok, 1);
        cyc();
        // Inst locked, then data rises: grant must not switch.
        idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c004040;
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h11112222;
        #1;
        chk("lock2_inst_data_ok", bus.inst_data_ok, 1);
        chk("lock2_inst_rdata", bus.inst_rdata, 32'h11112222);
        chk("lock2_refused", bus.inst_addr_ok, 0);
        cyc();
        idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c004040;
        dreq(1'b0, 4'h0, 32'h1c000020, 32'h0);
        #1;
        chk("lock2_held_addr", bus.mem_addr, 32'h1c004040);
        chk("lock2_data_blocked", bus.data_addr_ok, 0);
        cyc();
        bus.mem_addr_ok = 1'b1;
        #1;
        chk("lock2_inst_accept", bus.inst_addr_ok, 1);
        chk("lock2_data_lose", bus.data_addr_ok, 0);
        cyc();
        bus.inst_req = 1'b0;
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h33334444;
        #1;
        chk("lock2_data_accept", bus.data_addr_ok, 1);
        chk("lock2_inst_resp", bus.inst_rdata, 32'h33334444);
        cyc();
        idle();
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h55556666;
        #1;
        chk("lock2_data_resp", bus.data_rdata, 32'h55556666);
        cyc();

        // FIFO full: third request blocked even with a same-cycle pop.
        idle(); dreq(1'b0, 4'h0, 32'h1c000100, 0); bus.mem_addr_ok = 1'b1;
        #1; chk("full_acc0", bus.data_addr_ok, 1);
        cyc();
        bus.data_addr = 32'h1c000104;
        #1; chk("full_acc1", bus.data_addr_ok, 1);
        cyc();
        bus.data_addr = 32'h1c000108; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000f001;
        #1;
        chk("full_mem_req", bus.mem_req, 0);
        chk("full_addr_ok", bus.data_addr_ok, 0);
        chk("full_pop_rdata", bus.data_rdata, 32'h0000f001);
        cyc();
        bus.mem_data_ok = 1'b0;
        #1;
        chk("full_reassert", bus.mem_req, 1);
        chk("full_acc2", bus.data_addr_ok, 1);
        cyc();
        idle(); bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000f002;
        #1; chk("full_drain0", bus.data_rdata, 32'h0000f002);
        cyc();
        bus.mem_rdata = 32'h0000f003;
        #1; chk("full_drain1", bus.data_rdata, 32'h0000f003);
        cyc();
        bus.mem_rdata = 32'h0000f004;
        #1;
        chk("empty_data_ok", bus.data_data_ok, 0);
        chk("empty_inst_ok", bus.inst_data_ok, 0);
        chk("empty_rdata", bus.data_rdata, 0);
        cyc();

        // Cancel with a full FIFO: both stale fetches dropped, the post-flush fetch delivered.
        idle(); bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000200; bus.mem_addr_ok = 1'b1;
        #1; chk("can_acc0", bus.inst_addr_ok, 1);
        cyc();
        bus.inst_addr = 32'h1c000204;
        #1; chk("can_acc1", bus.inst_addr_ok, 1);
        cyc();
        bus.inst_addr = 32'h1c008000; bus.inst_cancel = 1'b1;
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000c001;
        #1;
        chk("can_full_req", bus.mem_req, 0);
        chk("can_drop0", bus.inst_data_ok, 0);
        cyc();
        bus.inst_cancel = 1'b0; bus.mem_rdata = 32'h0000c002;
        #1;
        chk("can_new_acc", bus.inst_addr_ok, 1);
        chk("can_new_addr", bus.mem_addr, 32'h1c008000);
        chk("can_drop1", bus.inst_data_ok, 0);
        cyc();
        bus.inst_req = 1'b0; bus.mem_rdata = 32'h0000c003;
        #1; chk("can_new_rdata", bus.inst_rdata, 32'h0000c003);
        cyc();

        // Cancel in the same cycle as the new fetch's accept.
        idle(); bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000300; bus.mem_addr_ok = 1'b1;
        #1; chk("can2_acc0", bus.inst_addr_ok, 1);
        cyc();
        bus.inst_addr = 32'h1c008000; bus.inst_cancel = 1'b1;
        #1; chk("can2_acc_new", bus.inst_addr_ok, 1);
        cyc();
        idle(); bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000d001;
        #1; chk("can2_drop", bus.inst_data_ok, 0);
        cyc();
        bus.mem_rdata = 32'h0000d002;
        #1; chk("can2_new_rdata", bus.inst_rdata, 32'h0000d002);
        cyc();

        // Data entries survive a cancel.
        idle(); dreq(1'b0, 4'h0, 32'h1c000400, 0); bus.mem_addr_ok = 1'b1;
        #1; chk("can3_data_acc", bus.data_addr_ok, 1);
        cyc();
        idle(); bus.inst_cancel = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000e001;
        #1; chk("can3_data_kept", bus.data_rdata, 32'h0000e001);
        cyc();

        // Reset with two outstanding entries.
        idle(); bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000500; bus.mem_addr_ok = 1'b1;
        #1; chk("rst2_acc0", bus.inst_addr_ok, 1);
        cyc();
        bus.inst_req = 1'b0; dreq(1'b0, 4'h0, 32'h1c000504, 0);
        #1; chk("rst2_acc1", bus.data_addr_ok, 1);
        cyc();
        bus.data_req = 1'b0; bus.inst_req = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000bad0;
        #1; chk("rst2_pre_resp", bus.inst_data_ok, 1);
        resetn = 1'b0;
        #1;
        chk("rst2_inst_data_ok", bus.inst_data_ok, 0);
        chk("rst2_inst_rdata", bus.inst_rdata, 0);
        chk("rst2_mem_req", bus.mem_req, 0);
        chk("rst2_mem_addr", bus.mem_addr, 0);
        chk("rst2_inst_addr_ok", bus.inst_addr_ok, 0);
        cyc();
        idle(); bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000bad1;
        resetn = 1'b1;
        #1;
        chk("rst2_stale_inst", bus.inst_data_ok, 0);
        chk("rst2_stale_data", bus.data_data_ok, 0);
        cyc();
        idle(); dreq(1'b1, 4'h3, 32'h1c000600, 32'h12345678); bus.mem_addr_ok = 1'b1;
        #1;
        chk("rst2_fresh_acc", bus.data_addr_ok, 1);
        chk("rst2_fresh_wstrb", bus.mem_wstrb, 4'h3);
        cyc();
        idle(); bus.mem_data_ok = 1'b1;
        #1; chk("rst2_fresh_ack", bus.data_data_ok, 1);
        cyc();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one sram-like memory port between the instruction-fetch requester and the data-access requester. It sits between the pipeline's inst/data request interfaces and the single cache/bridge port. It arbitrates address phases with data priority and inst anti-starvation, and holds a granted request until it is accepted. It routes in-order responses back through an owner FIFO and discards fetch responses made stale by a pipeline flush.

## Interface
Parameters:
- OUTSTANDING, 2, depth of the owner FIFO, i.e. max accepted-but-unanswered transactions (1..4)
- STARVE_LIMIT, 4, consecutive cycles inst may lose arbitration before it gets priority (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- resetn  in  1  reset, asynchronous, active-low
- inst_req  in  1  fetch request; payload held stable until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_cancel  in  1  flush pulse; stale fetch responses must be dropped
- inst_addr_ok  out  1  fetch address accepted this cycle
- inst_data_ok  out  1  fetch response valid this cycle
- inst_rdata  out  32  fetch response data
- data_req  in  1  data request; payload held stable until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte enables for writes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted this cycle
- data_data_ok  out  1  data response (read data or write ack) valid
- data_rdata  out  32  read data
- mem_req, mem_wr (1), mem_wstrb (4), mem_addr (32), mem_wdata (32)  out  shared-port request payload
- mem_addr_ok  in  1  shared port accepts the address this cycle
- mem_data_ok  in  1  shared port returns a response, in order
- mem_rdata  in  32  response data

## Operation
- **Selection.**
  - While `lock_valid`=1, owner = `lock_owner`.
  - Otherwise data wins if data_req=1, unless `starve_cnt` == STARVE_LIMIT; then inst wins if inst_req=1.
  - The loser's addr_ok is 0.
- **Request issue.**
  - mem_req = (selected requester's req) && !fifo_full.
  - The payload muxes from the selected requester.
  - For inst: mem_wr=0, mem_wstrb=0, mem_wdata=0.
- **Accept.** When mem_req && mem_addr_ok:
  - The owner's addr_ok = 1.
  - Push {owner, discard=0} into the FIFO.
  - Clear `lock_valid`.
- **Lock.** When mem_req && !mem_addr_ok:
  - `lock_valid` <= 1, `lock_owner` <= owner.
  - The grant cannot switch until accepted, so the payload seen by the memory stays constant.
- **Starvation counter** (4 bits).
  - Increments, saturating at STARVE_LIMIT, when inst_req=1 and data is the owner.
  - Clears to 0 on inst accept or when inst_req=0.
- **Response.** On mem_data_ok with FIFO non-empty:
  - Pop the head.
  - Head owner = data: data_data_ok=1, data_rdata=mem_rdata.
  - Head owner = inst and discard=0: inst_data_ok=1, inst_rdata=mem_rdata.
  - Head owner = inst and discard=1: the response is consumed silently.
- **Cancel.** inst_cancel=1 sets discard on every inst entry in the FIFO at the start of the cycle.
  - An inst request accepted in the cancel cycle is the new post-flush fetch and is pushed with discard=0.
  - Data entries are never discarded.
  - A locked, unaccepted inst request stays locked; the front end presents its new address under the same req.
- **Boundary cases.**
  - FIFO full: mem_req=0 even if a pop occurs the same cycle, so there is no data_ok→req combinational path.
  - Push and pop in the same cycle (not full): count unchanged, pointers both advance modulo OUTSTANDING.
  - mem_data_ok with FIFO empty: protocol violation; ignored, no output asserted.
- **Reset** (resetn=0, asynchronous):
  - FIFO empty, `lock_valid`=0, `starve_cnt`=0.
  - Every output is 0 while reset is held and until the next request.
  - Transactions in flight at reset are forgotten; later mem_data_ok for them is ignored as the empty-FIFO case.

## Timing
- The request path is combinational: req → mem_req in 0 cycles, mem_addr_ok → xx_addr_ok in 0 cycles.
- The response path is combinational: mem_data_ok → xx_data_ok in 0 cycles.
- The earliest response for a request is the cycle after its address is accepted. Arbitration adds no latency beyond the memory's own.
- Back-to-back accepts every cycle are sustained while the FIFO is not full and responses keep pace.
- Lock, FIFO pointers/count and starve_cnt update on posedge clk only; reset clears them asynchronously.

## Test plan
- **Priority and return.** inst_req and data_req both high, memory always addr_ok=1 with 1-cycle data_ok. Required:
  - data accepted on cycles 0..3.
  - inst accepted on cycle 4 (STARVE_LIMIT=4).
  - responses return to matching ports in order with correct rdata.
- **Lock.** Data write 0x1c000010/0xdeadbeef, wstrb=0xf, mem_addr_ok low for 3 cycles while inst_req rises. Required:
  - mem payload is unchanged across all 3 cycles.
  - data_addr_ok is asserted in cycle 3.
  - inst is not granted before then.
- **FIFO full.** OUTSTANDING=2, two accepts with no data_ok. Required:
  - mem_req=0 in the third cycle.
  - after one mem_data_ok, mem_req reasserts the next cycle.
- **Cancel.** Two inst fetches outstanding, then inst_cancel together with a new inst accept at 0x1c008000. Required:
  - the first two responses produce no inst_data_ok.
  - the third produces inst_data_ok with its rdata.
- **Reset mid-operation.** resetn low with 2 entries outstanding, then mem_data_ok after release. Required:
  - all outputs go to 0 asynchronously.
  - the post-release response is ignored.
  - a fresh request is then accepted normally.
